rf_scoreboard_file: RTL and testbench
=====================================

# rf_scoreboard_file

Integer register file with a per-register busy scoreboard for the multi-cycle pipelined RISC-V core. It consumes the `rf_readreg1`, `rf_readreg2` and `rf_writereg` indices extracted from the instruction word. It returns operand data, decides whether the instruction may issue under RAW/WAW hazards, and absorbs write-backs from the ALU and load paths. x0 reads as zero, is never written and is never busy.

## Interface
- `XLEN`, 64, register/data width (RV64: LD/SD/LWU supported)
- `NREG`, 32, architectural register count; index width 5
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `rf_readreg1`  in  5  rs1 index of the issuing instruction
- `rf_readreg2`  in  5  rs2 index of the issuing instruction
- `rf_writereg`  in  5  rd index of the issuing instruction
- `issue_valid`  in  1  an instruction is presented for issue
- `issue_uses_rs2`  in  1  instruction reads rs2 (ARITH, STORE, COND_BRA)
- `issue_wr_en`  in  1  instruction writes rd (ARITH, ADDI, LOAD, JAL, JALR)
- `issue_ready`  out  1  no hazard; issue accepted when `issue_valid & issue_ready`
- `rd_data1`  out  XLEN  rs1 operand, bypassed
- `rd_data2`  out  XLEN  rs2 operand, bypassed
- `wb_valid`  in  1  write-back strobe
- `wb_reg`  in  5  write-back destination
- `wb_data`  in  XLEN  write-back value
- `outstanding`  out  6  count of busy registers, 0..31
- `wb_orphan`  out  1  sticky: write-back arrived for a register that was not busy

## Operation
- Storage: `regs[1..31]` of XLEN; `busy[1..31]`. Index 0 reads 0, has no storage and is never busy.
- Read: `rd_data1 = (rs1==0) ? 0 : (wb_valid & wb_reg==rs1) ? wb_data : regs[rs1]`. `rd_data2` uses rs2 in the same way. Reads are combinational.
- Effective busy for this cycle: `eb[r] = busy[r] & ~(wb_valid & wb_reg==r)`. A same-cycle write-back resolves the hazard.
- `issue_ready = ~(eb[rs1] | (issue_uses_rs2 & eb[rs2]) | (issue_wr_en & eb[rd]))`. It is independent of `issue_valid`.
- Write-back with `wb_valid` and `wb_reg != 0`:
  - `regs[wb_reg] <= wb_data`.
  - `busy[wb_reg] <= 0`.
  - If `busy[wb_reg]` was already 0, the write still happens and `wb_orphan <= 1`.
  - `wb_reg == 0` is ignored entirely, with no orphan flag.
- Issue accept with `issue_wr_en` and `rd != 0`: `busy[rd] <= 1`.
- Simultaneous accept and write-back to the same rd: the set wins, so `busy` ends at 1. The new producer owns the register, and the data write still occurs.
- `outstanding` is the registered popcount of `busy` after each edge. It increments by 1 on a set-only cycle, decrements by 1 on a clear-only cycle, and is unchanged when both occur to the same register.
- `wb_orphan` is cleared only by `rst`.

## Timing
- Reset (async assert, sync-safe release):
  - all `regs = 0`, all `busy = 0`
  - `outstanding = 0`, `wb_orphan = 0`
  - therefore `issue_ready = 1` and `rd_data* = 0` while indices are nonzero
- Read latency: 0 cycles (combinational).
- Write-back visibility: the same cycle via bypass; from the array at edge+1.
- Scoreboard set is visible from edge+1. An instruction accepted at edge N that writes rd stalls a consumer of rd presented at N+1 until the matching write-back cycle.
- The write-back cycle itself may issue the dependent instruction: zero-bubble RAW for a single-cycle producer.
- Reset mid-operation discards all busy bits and data; in-flight write-backs after reset release set `wb_orphan`.

## Structure
- Shared package `rf_pkg`:
  - `XLEN`, `REG_IDX_W = 5`, `REG_X0 = 5'd0`
  - the opcode constants (ARITH, ADDI, COND_BRA, JAL, JALR, LOAD, STORE) used by the upstream decoder to drive `issue_uses_rs2` / `issue_wr_en`
- One sub-module, `rf_busy_table`: holds `busy[31:1]` and `outstanding`, and computes effective-busy lookups for the three ports plus the set/clear arbitration. The data array and bypass live in the top module.

## Test plan
- Reset, then write-back x5 = 0x1234 without a prior issue → `wb_orphan=1` and the x5 read returns 0x1234.
- Issue add x3 (wr_en, rd=3), then next cycle present rs1=3 → `issue_ready=0`. Assert write-back x3 = 0xA5 → same cycle `issue_ready=1` and `rd_data1=0xA5`; `outstanding` goes 1→0.
- Issue rd=0 with wr_en, then read x0 and write-back x0 = 0xFF → `busy` unchanged, `outstanding=0`, `rd_data1=0`, no orphan.
- Busy x7, then issue another wr_en rd=7 with no write-back → `issue_ready=0` (WAW). Repeat with a same-cycle write-back to x7 → accepted, `busy[7]` stays 1, `outstanding` stays 1.
- Store with rs2=9 busy and `issue_uses_rs2=1` → stall. The same rs2 with `issue_uses_rs2=0` → `issue_ready=1`.
- Set 31 registers busy, then assert `rst` mid-cycle → all outputs return to reset values asynchronously; `outstanding=0`.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register-index constants and RV opcode decode helpers.
package rf_pkg;
    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 6;

    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    localparam logic [6:0] ARITH    = 7'b0110011;
    localparam logic [6:0] ADDI     = 7'b0010011;
    localparam logic [6:0] COND_BRA = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return op inside {ARITH, STORE, COND_BRA};
    endfunction

    function automatic logic op_wr_en(input logic [6:0] op);
        return op inside {ARITH, ADDI, LOAD, JAL, JALR};
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/rf_busy_table.sv
// rf_busy_table: per-register busy bits with set/clear arbitration and outstanding count.
module rf_busy_table
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic                 set_en,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_reg,
    output logic                 eb_rs1,
    output logic                 eb_rs2,
    output logic                 eb_rd,
    output logic                 wb_hit_idle,
    output logic [CNT_W-1:0]     outstanding
);
    logic [NREG-1:0]  busy_q, busy_d, clr_mask, set_mask, eb;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    // Bit 0 is masked out of both masks, so x0 can never become busy.
    always_comb begin
        clr_mask      = (wb_valid ? NREG'(1) << wb_reg : '0) & ~NREG'(1);
        set_mask      = (set_en ? NREG'(1) << rd_idx : '0) & ~NREG'(1);
        eb            = busy_q & ~clr_mask;
        busy_d        = eb | set_mask;
        outstanding_d = popcount(busy_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign eb_rs1      = eb[rs1_idx];
    assign eb_rs2      = eb[rs2_idx];
    assign eb_rd       = eb[rd_idx];
    assign wb_hit_idle = wb_valid & (wb_reg != REG_X0) & ~busy_q[wb_reg];
    assign outstanding = outstanding_q;
endmodule

// File: rtl/rf_scoreboard_file.sv
// rf_scoreboard_file: integer register file with write-back bypass and RAW/WAW issue scoreboard.
module rf_scoreboard_file
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rf_readreg1,
    input  logic [REG_IDX_W-1:0] rf_readreg2,
    input  logic [REG_IDX_W-1:0] rf_writereg,
    input  logic                 issue_valid,
    input  logic                 issue_uses_rs2,
    input  logic                 issue_wr_en,
    output logic                 issue_ready,
    output logic [XLEN-1:0]      rd_data1,
    output logic [XLEN-1:0]      rd_data2,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_reg,
    input  logic [XLEN-1:0]      wb_data,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 wb_orphan
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wb_orphan_q, wb_orphan_d;
    logic            wb_we, set_en, eb_rs1, eb_rs2, eb_rd, wb_hit_idle;

    rf_busy_table u_busy (
        .clk         (clk),
        .rst         (rst),
        .rs1_idx     (rf_readreg1),
        .rs2_idx     (rf_readreg2),
        .rd_idx      (rf_writereg),
        .set_en      (set_en),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .eb_rs1      (eb_rs1),
        .eb_rs2      (eb_rs2),
        .eb_rd       (eb_rd),
        .wb_hit_idle (wb_hit_idle),
        .outstanding (outstanding)
    );

    // regs_q[0] is never written and stays zero, so it trims away in synthesis.
    always_comb begin
        wb_we       = wb_valid & (wb_reg != REG_X0);
        issue_ready = ~(eb_rs1 | (issue_uses_rs2 & eb_rs2) | (issue_wr_en & eb_rd));
        set_en      = issue_valid & issue_ready & issue_wr_en & (rf_writereg != REG_X0);
        wb_orphan_d = wb_orphan_q | wb_hit_idle;
        regs_d      = regs_q;
        if (wb_we) regs_d[wb_reg] = wb_data;
        rd_data1    = (rf_readreg1 == REG_X0) ? '0 :
                      (wb_valid && wb_reg == rf_readreg1) ? wb_data : regs_q[rf_readreg1];
        rd_data2    = (rf_readreg2 == REG_X0) ? '0 :
                      (wb_valid && wb_reg == rf_readreg2) ? wb_data : regs_q[rf_readreg2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            wb_orphan_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            wb_orphan_q <= wb_orphan_d;
        end
    end

    assign wb_orphan = wb_orphan_q;
endmodule

// File: tb/tb_rf_scoreboard_file.sv
// tb_rf_scoreboard_file: directed plus randomized checks against an array-based reference model.
module tb_rf_scoreboard_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rf_readreg1 = '0, rf_readreg2 = '0, rf_writereg = '0, wb_reg = '0;
    logic        issue_valid = 1'b0, issue_uses_rs2 = 1'b0, issue_wr_en = 1'b0, wb_valid = 1'b0;
    logic [63:0] wb_data = '0;
    logic        issue_ready, wb_orphan;
    logic [63:0] rd_data1, rd_data2;
    logic [5:0]  outstanding;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [63:0] m_regs [32];
    bit          m_busy [32];
    bit          m_orphan;

    rf_scoreboard_file dut (
        .clk            (clk),
        .rst            (rst),
        .rf_readreg1    (rf_readreg1),
        .rf_readreg2    (rf_readreg2),
        .rf_writereg    (rf_writereg),
        .issue_valid    (issue_valid),
        .issue_uses_rs2 (issue_uses_rs2),
        .issue_wr_en    (issue_wr_en),
        .issue_ready    (issue_ready),
        .rd_data1       (rd_data1),
        .rd_data2       (rd_data2),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .outstanding    (outstanding),
        .wb_orphan      (wb_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_orphan = 1'b0;
    endtask

    function automatic logic [63:0] m_rd(input logic [4:0] r);
        if (r == 0) return '0;
        if (wb_valid && wb_reg == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_eb(input logic [4:0] r);
        return r != 0 && m_busy[r] && !(wb_valid && wb_reg == r);
    endfunction

    function automatic logic [63:0] m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return 64'(n);
    endfunction

    task automatic drive(input bit iv, input bit us, input bit we, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input bit wv,
                         input logic [4:0] wr, input logic [63:0] wd);
        issue_valid = iv; issue_uses_rs2 = us; issue_wr_en = we;
        rf_readreg1 = a; rf_readreg2 = b; rf_writereg = d;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        #1;
    endtask

    // One issue/write-back cycle: combinational checks, clock edge, model update, registered checks.
    task automatic step(input bit iv, input bit us, input bit we, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input bit wv,
                        input logic [4:0] wr, input logic [63:0] wd);
        bit exp_ready;
        drive(iv, us, we, a, b, d, wv, wr, wd);
        exp_ready = !(m_eb(a) || (us && m_eb(b)) || (we && m_eb(d)));
        check("issue_ready", 64'(issue_ready), 64'(exp_ready));
        check("rd_data1", rd_data1, m_rd(a));
        check("rd_data2", rd_data2, m_rd(b));
        @(posedge clk);
        if (wv && wr != 0) begin
            if (!m_busy[wr]) m_orphan = 1'b1;
            m_regs[wr] = wd;
            m_busy[wr] = 1'b0;
        end
        if (iv && exp_ready && we && d != 0) m_busy[d] = 1'b1;
        #1;
        check("outstanding", 64'(outstanding), m_count());
        check("wb_orphan", 64'(wb_orphan), 64'(m_orphan));
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 1, 1, 5'd1, 5'd2, 5'd3, 0, 5'd0, 64'h0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_orphan", 64'(wb_orphan), 64'd0);
        check("rst_ready", 64'(issue_ready), 64'd1);
        check("rst_rd1", rd_data1, 64'd0);
        check("rst_rd2", rd_data2, 64'd0);

        // x0 as destination and write-back target is inert
        step(1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0);
        check("x0_no_busy", 64'(outstanding), 64'd0);
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 64'hFF);
        check("x0_read", rd_data1, 64'd0);
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 64'hFF);
        check("x0_no_orphan", 64'(wb_orphan), 64'd0);

        // orphan write-back still lands in the array
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd5, 64'h1234);
        check("orphan_set", 64'(wb_orphan), 64'd1);
        step(0, 0, 0, 5'd5, 5'd0, 5'd0, 0, 5'd0, 64'h0);
        check("orphan_data", rd_data1, 64'h1234);

        // RAW stall then zero-bubble release on write-back
        step(1, 1, 1, 5'd1, 5'd2, 5'd3, 0, 5'd0, 64'h0);
        check("raw_out1", 64'(outstanding), 64'd1);
        drive(1, 0, 0, 5'd3, 5'd0, 5'd0, 0, 5'd0, 64'h0);
        check("raw_stall", 64'(issue_ready), 64'd0);
        step(1, 0, 0, 5'd3, 5'd0, 5'd0, 0, 5'd0, 64'h0);
        drive(1, 0, 0, 5'd3, 5'd0, 5'd0, 1, 5'd3, 64'hA5);
        check("raw_release", 64'(issue_ready), 64'd1);
        check("raw_bypass", rd_data1, 64'hA5);
        step(1, 0, 0, 5'd3, 5'd0, 5'd0, 1, 5'd3, 64'hA5);
        check("raw_out0", 64'(outstanding), 64'd0);

        // WAW stall, then same-cycle write-back lets the new producer keep rd busy
        step(1, 0, 1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 64'h0);
        drive(1, 0, 1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 64'h0);
        check("waw_stall", 64'(issue_ready), 64'd0);
        step(1, 0, 1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 64'h0);
        drive(1, 0, 1, 5'd0, 5'd0, 5'd7, 1, 5'd7, 64'h77);
        check("waw_accept", 64'(issue_ready), 64'd1);
        step(1, 0, 1, 5'd0, 5'd0, 5'd7, 1, 5'd7, 64'h77);
        check("waw_still_busy", 64'(outstanding), 64'd1);
        step(0, 0, 0, 5'd7, 5'd0, 5'd0, 1, 5'd7, 64'h78);
        check("waw_cleared", 64'(outstanding), 64'd0);

        // rs2 hazard only counts when the instruction reads rs2
        step(1, 0, 1, 5'd0, 5'd0, 5'd9, 0, 5'd0, 64'h0);
        drive(1, 1, 0, 5'd0, 5'd9, 5'd0, 0, 5'd0, 64'h0);
        check("rs2_stall", 64'(issue_ready), 64'd0);
        step(1, 1, 0, 5'd0, 5'd9, 5'd0, 0, 5'd0, 64'h0);
        drive(1, 0, 0, 5'd0, 5'd9, 5'd0, 0, 5'd0, 64'h0);
        check("rs2_unused", 64'(issue_ready), 64'd1);
        step(1, 0, 0, 5'd0, 5'd9, 5'd0, 0, 5'd0, 64'h0);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd9, 64'h99);

        // random traffic concentrated on a few registers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a, b, d, w;
            logic [4:0] hi;
            hi = (i % 8 == 0) ? 5'd31 : 5'd7;
            a = 5'($urandom_range(0, int'(hi)));
            b = 5'($urandom_range(0, int'(hi)));
            d = 5'($urandom_range(0, int'(hi)));
            w = 5'($urandom_range(0, int'(hi)));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 a, b, d, 1'($urandom_range(0, 1)), w, {$urandom(), $urandom()});
        end

        // fill every register, then assert reset asynchronously mid-cycle
        for (int r = 1; r < 32; r++) step(1, 0, 1, 5'd0, 5'd0, 5'(r), 0, 5'd0, 64'h0);
        check("fill_31", 64'(outstanding), 64'd31);
        drive(0, 1, 1, 5'd5, 5'd31, 5'd4, 0, 5'd0, 64'h0);
        rst = 1'b1;
        #1;
        check("async_outstanding", 64'(outstanding), 64'd0);
        check("async_orphan", 64'(wb_orphan), 64'd0);
        check("async_ready", 64'(issue_ready), 64'd1);
        check("async_rd1", rd_data1, 64'd0);
        check("async_rd2", rd_data2, 64'd0);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // a write-back still in flight across reset is an orphan
        step(0, 0, 0, 5'd12, 5'd0, 5'd0, 1, 5'd12, 64'hDEAD);
        check("post_rst_orphan", 64'(wb_orphan), 64'd1);
        step(0, 0, 0, 5'd12, 5'd0, 5'd0, 0, 5'd0, 64'h0);
        check("post_rst_data", rd_data1, 64'hDEAD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
